uart_tx_ctrl: RTL and testbench

UART transmit serializer that drains the 8-entry transmit FIFO and drives the serial `tx` line. It pops one byte when the FIFO is non-empty and frames it as start bit, 8 data bits (LSB first), optional parity bit, and one stop bit. Bit period is set by a run-time clock-divider value. It sits directly downstream of the TX FIFO, and its `tx` output is the chip-level UART TX pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 115 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame width and idle line level
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter, reload on load, bit_done when it reads 0
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    output logic             bit_done
);

    logic [DIV_W-1:0] cnt;

    // Reload with period-1 at each bit start, otherwise count down and park at 0
    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= period - DIV_W'(1);
        else if (cnt != '0)
            cnt <= cnt - DIV_W'(1);
    end

    assign bit_done = (cnt == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: drains the TX FIFO and serializes 8N1 frames onto tx.
// Define UART_TX_PARITY_EN to add a parity bit (odd/even via parity_odd).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
`ifdef UART_TX_PARITY_EN
    input  logic             parity_odd,
`endif
    output logic             tx,
    output logic             busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e      state, state_nxt;
    logic [7:0]       shift;
    logic [2:0]       idx;
    logic [DIV_W-1:0] period, div_eff, tick_period;
    logic             pop, load, bit_done;
`ifdef UART_TX_PARITY_EN
    logic             par;
`endif

    // A divider of 0 behaves as 1; the new period applies to the bit timer on the pop cycle itself
    assign div_eff     = (clk_div == '0) ? DIV_W'(1) : clk_div;
    assign tick_period = pop ? div_eff : period;
    assign load        = pop || (state != IDLE && bit_done);
    assign fifo_rd_en  = pop;
    assign busy        = reset_n && (state != IDLE || pop);

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .period   (tick_period),
        .bit_done (bit_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, pop strobe and line level; pops only from IDLE or the last STOP cycle
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx        = UART_IDLE_LEVEL;
        case (state)
            IDLE: begin
                pop       = !fifo_empty;
                state_nxt = pop ? START : IDLE;
            end
            START: begin
                tx        = 1'b0;
                state_nxt = bit_done ? DATA : START;
            end
            DATA: begin
                tx = shift[0];
`ifdef UART_TX_PARITY_EN
                state_nxt = (bit_done && idx == LAST_BIT) ? PARITY : DATA;
`else
                state_nxt = (bit_done && idx == LAST_BIT) ? STOP : DATA;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx        = par;
                state_nxt = bit_done ? STOP : PARITY;
            end
`endif
            STOP: begin
                pop       = bit_done && !fifo_empty;
                state_nxt = bit_done ? (pop ? START : IDLE) : STOP;
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset_n)
            pop = 1'b0;
    end

    // Frame datapath: capture byte, period and parity on pop; shift out LSB first during DATA
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift  <= '0;
            idx    <= '0;
            period <= '0;
`ifdef UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else if (pop) begin
            shift  <= fifo_data;
            idx    <= '0;
            period <= div_eff;
`ifdef UART_TX_PARITY_EN
            par    <= ^fifo_data ^ parity_odd;
`endif
        end else if (state == DATA && bit_done) begin
            shift  <= shift >> 1;
            idx    <= idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: FIFO model + frame scoreboard checking tx, fifo_rd_en and busy every cycle
module tb_uart_tx_ctrl;

    localparam int DIV_W = 16;

    typedef struct {
        logic [10:0] bits;
        int          len;
        int          p;
    } frame_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [DIV_W-1:0] clk_div;
    logic             parity_odd;
    logic             fifo_empty, fifo_rd_en, tx, busy;
    logic [7:0]       fifo_data;
    logic [7:0]       mem [256];
    logic [7:0]       wr_ptr;
    logic [7:0]       rd_ptr = 8'd0;
    logic             rst_d = 1'b0;

    frame_t q[$];
    frame_t cur;
    logic   in_frame = 1'b0;
    int     cyc = 0;
    logic   last, exp_tx, exp_rd;
    int     nvec = 0;
    int     nerr = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr];

    uart_tx_ctrl #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_div    (clk_div),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx),
        .busy       (busy)
    );

    // FIFO read side and registered copy of reset as seen by the DUT
    always @(posedge clk) begin
        rst_d <= reset_n;
        if (fifo_rd_en && !fifo_empty)
            rd_ptr <= rd_ptr + 8'd1;
    end

    // Expected frame: start 0, data LSB first, optional parity, stop 1; each bit P cycles
    function automatic frame_t make_frame(logic [7:0] d, logic [DIV_W-1:0] div, logic po);
        frame_t f;
        f.p       = (div == '0) ? 1 : int'(div);
        f.bits    = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            f.bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f.bits[9] = (^d) ^ po;
        f.len     = 11;
`else
        f.len     = 10 + 0 * int'(po);
`endif
        return f;
    endfunction

    task automatic chk(string name, logic act, logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: pops a frame when its start bit is due and compares every cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            if (!rst_d) begin
                chk("reset_tx", tx, 1'b1);
                chk("reset_busy", busy, 1'b0);
            end
            chk("reset_rd_en", fifo_rd_en, 1'b0);
            in_frame = 1'b0;
            q.delete();
        end else begin
            if (!in_frame && q.size() != 0) begin
                cur      = q.pop_front();
                in_frame = 1'b1;
                cyc      = 0;
            end
            last   = in_frame && (cyc == cur.len * cur.p - 1);
            exp_tx = in_frame ? cur.bits[cyc / cur.p] : 1'b1;
            exp_rd = !fifo_empty && (!in_frame || last);
            chk("tx", tx, exp_tx);
            chk("fifo_rd_en", fifo_rd_en, exp_rd);
            chk("busy", busy, in_frame || exp_rd);
            if (fifo_rd_en && !fifo_empty)
                q.push_back(make_frame(fifo_data, clk_div, parity_odd));
            if (in_frame) begin
                cyc++;
                if (last)
                    in_frame = 1'b0;
            end
        end
    end

    task automatic push(logic [7:0] d);
        int n = 0;
        while (8'(wr_ptr - rd_ptr) >= 8'd8) begin
            @(posedge clk);
            #1;
            if (++n > 5000) begin
                $display("FAIL fifo_full_timeout: fifo never drained below 8 entries");
                $fatal(1);
            end
        end
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic wait_idle();
        int n = 0;
        int quiet = 0;
        while (quiet < 3) begin
            @(posedge clk);
            #1;
            quiet = (fifo_empty && !busy) ? quiet + 1 : 0;
            if (++n > 20000) begin
                $display("FAIL idle_timeout: busy=%b fifo_empty=%b, expected busy=0 fifo_empty=1", busy, fifo_empty);
                $fatal(1);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        clk_div    = DIV_W'(4);
        parity_odd = 1'b0;
        mem[0]     = 8'hA5;
        wr_ptr     = 8'd1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_idle();

        clk_div = DIV_W'(1);
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        clk_div    = DIV_W'(2);
        parity_odd = 1'b0;
        push(8'h07);
        wait_idle();
        parity_odd = 1'b1;
        push(8'h07);
        wait_idle();
`endif

        clk_div = DIV_W'(0);
        push(8'h96);
        push(8'h69);
        wait_idle();

        clk_div = DIV_W'(4);
        push(8'h33);
        push(8'hCC);
        repeat (10) @(posedge clk);
        #1 clk_div = DIV_W'(8);
        wait_idle();

        clk_div = DIV_W'(4);
        push(8'hF0);
        push(8'h81);
        @(posedge clk);
        repeat (17) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            clk_div    = DIV_W'($urandom_range(0, 3));
            parity_odd = 1'($urandom_range(0, 1));
            push(8'($urandom));
            repeat ($urandom_range(1, 25)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
